// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencing controller for the MIPS-subset datapath.
// One state per datapath step; the ALU and the unified memory are shared
// across steps, and every mux/enable is driven from the current state.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OPCode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_EXEC_I    = 4'd10;
  localparam logic [3:0] S_I_WB      = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [3:0] state_q;
  logic [3:0] state_d;

  // Next-state selection; memory states hold until mem_ready, unused codes recover to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (OPCode)
          OP_RTYPE:      state_d = S_EXEC_R;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_ADDI:       state_d = S_EXEC_I;
          default:       state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (OPCode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_EXEC_I:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // State register with synchronous active-low reset back to FETCH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath controls per state; everything is gated off while reset is held so no write leaks out
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    state       = 4'd0;
    if (rst_n) begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          case (OPCode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
            default: begin
              illegal_op = 1'b1;
              instr_done = 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_R_WB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        S_EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_I_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: state = state_q;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: one check per cycle of the whole
// output vector against hand-derived expected control words.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [5:0] OPCode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegWrite, RegDst, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  int compareCount;
  int mismatchCount;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .OPCode(OPCode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packs a full control word in a fixed field order for single-shot comparison
  function automatic logic [21:0] ctl(
    input logic pcw, input logic pcwc, input logic iord, input logic mr,
    input logic mw, input logic irw, input logic m2r, input logic rw,
    input logic rd, input logic asa, input logic [1:0] asb,
    input logic [1:0] aop, input logic [1:0] pcs, input logic done,
    input logic ill, input logic [3:0] st);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, asa, asb, aop, pcs, done, ill, st};
  endfunction

  // Drives one cycle of inputs, away from the rising edge
  task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic rdy);
    @(negedge clk);
    rst_n     = rst;
    OPCode    = op;
    mem_ready = rdy;
  endtask

  // Compares the whole observed control word against the expected one
  task automatic checkOutput(input string tag, input logic [21:0] expected);
    logic [21:0] observed;
    #1;
    observed = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                instr_done, illegal_op, state};
    compareCount++;
    assert (observed === expected) else begin
      mismatchCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  logic [21:0] eZero, eFetch, eFetchWait, eDecode, eDecodeIll, eMemAddr, eMemRead;
  logic [21:0] eMemWb, eMemWrWait, eMemWrDone, eExecR, eRWb, eBranch, eJump;
  logic [21:0] eExecI, eIWb;

  // Linear directed sequence covering every instruction class and the reset paths
  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst_n     = 1'b0;
    OPCode    = 6'b000000;
    mem_ready = 1'b1;

    //               pcw pcwc iord mr mw irw m2r rw rd asa asb    aop    pcs    done ill st
    eZero      = ctl(0,  0,   0,   0, 0, 0,  0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 0,   0,  4'd0);
    eFetch     = ctl(1,  0,   0,   1, 0, 1,  0,  0, 0, 0,  2'b01, 2'b00, 2'b00, 0,   0,  4'd0);
    eFetchWait = ctl(0,  0,   0,   1, 0, 0,  0,  0, 0, 0,  2'b01, 2'b00, 2'b00, 0,   0,  4'd0);
    eDecode    = ctl(0,  0,   0,   0, 0, 0,  0,  0, 0, 0,  2'b11, 2'b00, 2'b00, 0,   0,  4'd1);
    eDecodeIll = ctl(0,  0,   0,   0, 0, 0,  0,  0, 0, 0,  2'b11, 2'b00, 2'b00, 1,   1,  4'd1);
    eMemAddr   = ctl(0,  0,   0,   0, 0, 0,  0,  0, 0, 1,  2'b10, 2'b00, 2'b00, 0,   0,  4'd2);
    eMemRead   = ctl(0,  0,   1,   1, 0, 0,  0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 0,   0,  4'd3);
    eMemWb     = ctl(0,  0,   0,   0, 0, 0,  1,  1, 0, 0,  2'b00, 2'b00, 2'b00, 1,   0,  4'd4);
    eMemWrWait = ctl(0,  0,   1,   0, 1, 0,  0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 0,   0,  4'd5);
    eMemWrDone = ctl(0,  0,   1,   0, 1, 0,  0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 1,   0,  4'd5);
    eExecR     = ctl(0,  0,   0,   0, 0, 0,  0,  0, 0, 1,  2'b00, 2'b10, 2'b00, 0,   0,  4'd6);
    eRWb       = ctl(0,  0,   0,   0, 0, 0,  0,  1, 1, 0,  2'b00, 2'b00, 2'b00, 1,   0,  4'd7);
    eBranch    = ctl(0,  1,   0,   0, 0, 0,  0,  0, 0, 1,  2'b00, 2'b01, 2'b01, 1,   0,  4'd8);
    eJump      = ctl(1,  0,   0,   0, 0, 0,  0,  0, 0, 0,  2'b00, 2'b00, 2'b10, 1,   0,  4'd9);
    eExecI     = ctl(0,  0,   0,   0, 0, 0,  0,  0, 0, 1,  2'b10, 2'b00, 2'b00, 0,   0,  4'd10);
    eIWb       = ctl(0,  0,   0,   0, 0, 0,  0,  1, 0, 0,  2'b00, 2'b00, 2'b00, 1,   0,  4'd11);

    $display("[TB] start");

    // Power-on reset with mem_ready high: Mealy terms must still read 0
    applyStimulus(0, 6'b000000, 1); checkOutput("reset0", eZero);
    applyStimulus(0, 6'b000000, 1); checkOutput("reset1", eZero);

    // R-type, no waits: 0,1,6,7
    applyStimulus(1, 6'b000000, 1); checkOutput("r_fetch", eFetch);
    applyStimulus(1, 6'b000000, 1); checkOutput("r_decode", eDecode);
    applyStimulus(1, 6'b000000, 1); checkOutput("r_exec", eExecR);
    applyStimulus(1, 6'b000000, 1); checkOutput("r_wb", eRWb);

    // lw with two wait cycles in MEM_READ: 0,1,2,3,3,3,4
    applyStimulus(1, 6'b100011, 1); checkOutput("lw_fetch", eFetch);
    applyStimulus(1, 6'b100011, 1); checkOutput("lw_decode", eDecode);
    applyStimulus(1, 6'b100011, 1); checkOutput("lw_addr", eMemAddr);
    applyStimulus(1, 6'b100011, 0); checkOutput("lw_read_w0", eMemRead);
    applyStimulus(1, 6'b100011, 0); checkOutput("lw_read_w1", eMemRead);
    applyStimulus(1, 6'b100011, 1); checkOutput("lw_read_go", eMemRead);
    applyStimulus(1, 6'b100011, 1); checkOutput("lw_wb", eMemWb);

    // sw with a two-cycle fetch stall and one write wait
    applyStimulus(1, 6'b101011, 0); checkOutput("sw_fetch_w0", eFetchWait);
    applyStimulus(1, 6'b101011, 0); checkOutput("sw_fetch_w1", eFetchWait);
    applyStimulus(1, 6'b101011, 1); checkOutput("sw_fetch_go", eFetch);
    applyStimulus(1, 6'b101011, 0); checkOutput("sw_decode_rdy0", eDecode);
    applyStimulus(1, 6'b101011, 0); checkOutput("sw_addr_rdy0", eMemAddr);
    applyStimulus(1, 6'b101011, 0); checkOutput("sw_write_w0", eMemWrWait);
    applyStimulus(1, 6'b101011, 1); checkOutput("sw_write_go", eMemWrDone);

    // beq: 0,1,8
    applyStimulus(1, 6'b000100, 1); checkOutput("beq_fetch", eFetch);
    applyStimulus(1, 6'b000100, 1); checkOutput("beq_decode", eDecode);
    applyStimulus(1, 6'b000100, 1); checkOutput("beq_branch", eBranch);

    // j: 0,1,9
    applyStimulus(1, 6'b000010, 1); checkOutput("j_fetch", eFetch);
    applyStimulus(1, 6'b000010, 1); checkOutput("j_decode", eDecode);
    applyStimulus(1, 6'b000010, 1); checkOutput("j_jump", eJump);

    // addi: 0,1,10,11
    applyStimulus(1, 6'b001000, 1); checkOutput("addi_fetch", eFetch);
    applyStimulus(1, 6'b001000, 1); checkOutput("addi_decode", eDecode);
    applyStimulus(1, 6'b001000, 1); checkOutput("addi_exec", eExecI);
    applyStimulus(1, 6'b001000, 1); checkOutput("addi_wb", eIWb);

    // Illegal opcode: flagged in DECODE, straight back to FETCH
    applyStimulus(1, 6'b111111, 1); checkOutput("ill_fetch", eFetch);
    applyStimulus(1, 6'b111111, 1); checkOutput("ill_decode", eDecodeIll);
    applyStimulus(1, 6'b111111, 1); checkOutput("ill_next_fetch", eFetch);

    // Reset held for three cycles in the middle of an R-type
    applyStimulus(1, 6'b000000, 1); checkOutput("rr_decode", eDecode);
    applyStimulus(1, 6'b000000, 1); checkOutput("rr_exec", eExecR);
    applyStimulus(0, 6'b000000, 1); checkOutput("rr_reset0", eZero);
    applyStimulus(0, 6'b000000, 1); checkOutput("rr_reset1", eZero);
    applyStimulus(0, 6'b000000, 1); checkOutput("rr_reset2", eZero);
    applyStimulus(1, 6'b000000, 1); checkOutput("rr_fetch", eFetch);
    applyStimulus(1, 6'b000000, 1); checkOutput("rr_decode2", eDecode);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multi-cycle sequencing controller for the MIPS-subset datapath. It replaces single-cycle decode with a per-instruction state machine that time-shares one ALU and one unified instruction/data memory across fetch, decode, execute, memory and write-back steps. It drives every datapath mux/enable per cycle and waits on a memory ready handshake. Supported opcodes: R-type, lw, sw, beq, j, addi.

## Interface
- No parameters; state encoding fixed below.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- OPCode  in  6  instruction[31:26] from IR; sampled only in DECODE.
- mem_ready  in  1  memory completes current access this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  out  1 each  datapath controls.
- ALUSrcB  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- ALUOp  out  2  00 add, 01 subtract (beq), 10 funct-decoded.
- PCSource  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump address.
- instr_done  out  1  one-cycle pulse on last cycle of each instruction.
- illegal_op  out  1  one-cycle pulse in DECODE for unsupported opcode.
- state  out  4  current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, I_WB=11. Codes 12-15 unreachable; if entered, next state FETCH, outputs all 0.
- Unlisted outputs are 0 in each state.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready (Mealy). Stay until mem_ready=1, then DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next: 000000->EXEC_R; 100011 or 101011->MEM_ADDR; 000100->BRANCH; 000010->JUMP; 001000->EXEC_I; other->FETCH with illegal_op=1 and instr_done=1.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next MEM_READ if OPCode=100011, else MEM_WRITE (OPCode held stable by IR).
- MEM_READ: MemRead=1, IorD=1; wait for mem_ready, then MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1, instr_done=1 -> FETCH.
- MEM_WRITE: MemWrite=1, IorD=1; wait for mem_ready; instr_done=mem_ready; then FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> R_WB. R_WB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1 -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> I_WB. I_WB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1 -> FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1 -> FETCH.
- MemRead and MemWrite are never both 1. RegWrite is never 1 during FETCH or DECODE.

## Timing
- Reset: on any rising edge with rst_n=0, state<=FETCH. While rst_n=0, all outputs are forced to 0 combinationally, including the Mealy terms and state output reading 0. First fetch starts on the first cycle with rst_n=1.
- Reset mid-instruction: abandons the instruction. No write is issued in the reset cycle. The next cycle is FETCH.
- Latency with mem_ready tied 1: beq/j 3 cycles; R-type/addi/sw 4; lw 5. Each wait cycle on mem_ready adds 1 cycle in FETCH, MEM_READ or MEM_WRITE.
- Memory control signals are held stable while waiting. mem_ready outside FETCH, MEM_READ or MEM_WRITE is ignored.
- Illegal opcode: 2 cycles total (FETCH, DECODE). No register, memory or PC write beyond the fetch PC+4.

## Test plan
- Reset: hold rst_n=0 for 3 cycles mid-EXEC_R -> all outputs 0. After release, state=0, MemRead=1, IorD=0, ALUSrcB=01.
- R-type, mem_ready=1: OPCode=000000 -> states 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7. instr_done pulses once.
- lw with 2 wait cycles in MEM_READ: OPCode=100011 -> states 0,1,2,3,3,3,4. MemRead=1 and IorD=1 held for all three state-3 cycles. MemtoReg=1 and RegWrite=1 in state 4. Total 7 cycles.
- sw and fetch stall: mem_ready=0 for 2 cycles in FETCH -> IRWrite=PCWrite=0 until mem_ready=1. OPCode=101011 then reaches state 5 with MemWrite=1, and RegWrite never asserts.
- beq/j: OPCode=000100 -> state 8 with PCWriteCond=1, PCSource=01, ALUOp=01. OPCode=000010 -> state 9 with PCWrite=1, PCSource=10. Each takes 3 cycles.
- Illegal opcode: OPCode=111111 -> illegal_op=1 and instr_done=1 in DECODE, next state 0. No RegWrite or MemWrite asserted.
